// File: rtl/os_feeder_pkg.sv
// Shared types and sizing helpers for the operand skew feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package os_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int DEF_A_H = 32;
  localparam int DEF_B_W = 32;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Wide enough for the longest down-count (drain) with headroom, so no wrap.
  function automatic int cnt_width(input int a_h, input int b_w, input int drain_cyc);
    return $clog2(a_h + b_w + drain_cyc) + 1;
  endfunction

  // Zero-shift cycles needed to push the last slice through the deepest lane.
  function automatic int flush_cycles(input int a_h, input int b_w);
    return max2(a_h, b_w) - 1;
  endfunction

  localparam int FLUSH_CYC = flush_cycles(DEF_A_H, DEF_B_W);

endpackage

// File: rtl/os_operand_skew_feeder_skew_lane_delay.sv
// Fixed-depth lane delay: DEPTH shift stages followed by one output register.
// Latency: DEPTH+1 cycles from din to dout; DEPTH=0 is the output register alone.
// Backpressure: none, shifts every cycle.
module skew_lane_delay #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_direct
    // Output register only: lane 0 has no skew.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout <= '0;
      else        dout <= din;
    end
  end else begin : g_shift
    logic [WIDTH-1:0] sr [DEPTH];

    // Shift chain plus output register; every stage clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        dout <= '0;
      end else begin
        sr[0] <= din;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        dout <= sr[DEPTH-1];
      end
    end
  end

endmodule

// File: rtl/os_operand_skew_feeder.sv
// Operand feeder for an output-stationary MAC array: clears, streams skewed k-slices, flushes, drains, signals done.
// Latency: slice accepted at t shows on A lane i at t+1+i, B lane j at t+1+j; tile_done FLUSH+DRAIN+1 cycles after last accept.
// Backpressure: in_ready high only in STREAM; idle input cycles inject zero bubbles on all lanes. Optional OS_FEEDER_PERF_CNT_EN adds perf counters.
module os_operand_skew_feeder
  import os_feeder_pkg::*;
#(
  parameter int A_H       = DEF_A_H,
  parameter int B_W       = DEF_B_W,
  parameter int WIDTH     = 8,
  parameter int DRAIN_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_H*WIDTH-1:0] in_a,
  input  logic [B_W*WIDTH-1:0] in_b,
  input  logic                 in_last,
  output logic [A_H*WIDTH-1:0] A,
  output logic [B_W*WIDTH-1:0] B,
  output logic                 clc,
  output logic                 busy,
  output logic                 tile_done
`ifdef OS_FEEDER_PERF_CNT_EN
  ,
  output logic [15:0]          bubble_cnt,
  output logic [15:0]          slice_cnt
`endif
);

  localparam int FLUSH_LEN  = flush_cycles(A_H, B_W);
  localparam int DRAIN_LEN  = (A_H + B_W - 2) + DRAIN_CYC;
  localparam int CW         = cnt_width(A_H, B_W, DRAIN_CYC);
  localparam int FLUSH_LOAD = (FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0;
  localparam int DRAIN_LOAD = (DRAIN_LEN > 0) ? DRAIN_LEN - 1 : 0;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic [A_H*WIDTH-1:0] a_lane_in;
  logic [B_W*WIDTH-1:0] b_lane_in;

  assign accept = in_valid & in_ready & (state == STREAM);

  // Non-accept cycles feed zeros into every lane so A/B stay aligned.
  assign a_lane_in = accept ? in_a : '0;
  assign b_lane_in = accept ? in_b : '0;

  // Tile sequencer with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      clc       <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      clc       <= 1'b0;
      tile_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= CLEAR;
            clc   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          state    <= STREAM;
          in_ready <= 1'b1;
        end
        STREAM: begin
          if (accept && in_last) begin
            in_ready <= 1'b0;
            if (FLUSH_LEN > 0) begin
              state <= FLUSH;
              cnt   <= CW'(FLUSH_LOAD);
            end else if (DRAIN_LEN > 0) begin
              state <= DRAIN;
              cnt   <= CW'(DRAIN_LOAD);
            end else begin
              state     <= DONE;
              tile_done <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (cnt == '0) begin
            if (DRAIN_LEN > 0) begin
              state <= DRAIN;
              cnt   <= CW'(DRAIN_LOAD);
            end else begin
              state     <= DONE;
              tile_done <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DRAIN: begin
          if (cnt == '0) begin
            state     <= DONE;
            tile_done <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Diagonal skew: lane i of A is delayed i extra cycles.
  for (genvar i = 0; i < A_H; i++) begin : g_a_lane
    skew_lane_delay #(.DEPTH(i), .WIDTH(WIDTH)) u_dly (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (a_lane_in[i*WIDTH +: WIDTH]),
      .dout (A[i*WIDTH +: WIDTH])
    );
  end

  // Diagonal skew: lane j of B is delayed j extra cycles.
  for (genvar j = 0; j < B_W; j++) begin : g_b_lane
    skew_lane_delay #(.DEPTH(j), .WIDTH(WIDTH)) u_dly (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (b_lane_in[j*WIDTH +: WIDTH]),
      .dout (B[j*WIDTH +: WIDTH])
    );
  end

`ifdef OS_FEEDER_PERF_CNT_EN
  // Saturating per-tile counts of accepted slices and idle STREAM cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      slice_cnt  <= '0;
    end else if (state == CLEAR) begin
      bubble_cnt <= '0;
      slice_cnt  <= '0;
    end else if (state == STREAM) begin
      if (accept) begin
        if (slice_cnt != 16'hFFFF) slice_cnt <= slice_cnt + 16'd1;
      end else begin
        if (bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_os_operand_skew_feeder.sv
// Directed bench for the skew feeder with a small output-stationary array model as consumer.
// Latency: n/a.
// Backpressure: n/a.
module tb_os_operand_skew_feeder;

  localparam int N = 4;
  localparam int W = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic [N*W-1:0]  in_a;
  logic [N*W-1:0]  in_b;
  logic            in_last;
  logic [N*W-1:0]  A;
  logic [N*W-1:0]  B;
  logic            clc;
  logic            busy;
  logic            tile_done;
`ifdef OS_FEEDER_PERF_CNT_EN
  logic [15:0]     bubble_cnt;
  logic [15:0]     slice_cnt;
`endif

  os_operand_skew_feeder #(.A_H(N), .B_W(N), .WIDTH(W), .DRAIN_CYC(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .A        (A),
    .B        (B),
    .clc      (clc),
    .busy     (busy),
    .tile_done(tile_done)
`ifdef OS_FEEDER_PERF_CNT_EN
    ,
    .bubble_cnt(bubble_cnt),
    .slice_cnt (slice_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int clc_cnt = 0;
  logic [N*W-1:0] ha [0:4095];
  logic [N*W-1:0] hb [0:4095];

  // Output-stationary array model: A flows right, B flows down, PE accumulates.
  logic signed [W-1:0] a_r [N][N];
  logic signed [W-1:0] b_r [N][N];
  int acc [N][N];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == 0) a_r[i][j] <= A[i*W +: W];
        else        a_r[i][j] <= a_r[i][j-1];
        if (i == 0) b_r[i][j] <= B[j*W +: W];
        else        b_r[i][j] <= b_r[i-1][j];
        if (clc) acc[i][j] <= 0;
        else     acc[i][j] <= acc[i][j] + int'(a_r[i][j]) * int'(b_r[i][j]);
      end
    end
  end

  // Output history and pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (cyc < 4096) begin
      ha[cyc] <= A;
      hb[cyc] <= B;
    end
    if (tile_done) done_cnt <= done_cnt + 1;
    if (clc)       clc_cnt  <= clc_cnt + 1;
  end

  typedef struct {
    int scen;
    bit is_b;
    int lane;
    int rel;
    int exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int s, input bit b, input int l, input int r, input int e);
    vec_t v;
    v.scen = s; v.is_b = b; v.lane = l; v.rel = r; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] make_a(input int k);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = 8'(i*4 + k + 1);
    return r;
  endfunction

  function automatic logic [N*W-1:0] make_b(input int k);
    logic [N*W-1:0] r;
    for (int j = 0; j < N; j++) r[j*W +: W] = 8'(k*4 + j + 1);
    return r;
  endfunction

  function automatic int gold(input int i, input int j);
    int s = 0;
    for (int k = 0; k < N; k++) s += (i*4 + k + 1) * (k*4 + j + 1);
    return s;
  endfunction

  // Called at a negedge; returns at a negedge after the accept edge.
  task automatic send(input logic [N*W-1:0] a, input logic [N*W-1:0] b, input bit last, output int acc_c);
    in_a = a; in_b = b; in_valid = 1'b1; in_last = last; acc_c = -1;
    for (int n = 0; n < 20; n++) begin
      if (in_ready) begin
        acc_c = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc_c < 0) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: in_ready never rose within 20 cycles");
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic start_tile();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("clear_clc", clc, 1);
    chk("clear_busy", busy, 1);
    chk("clear_in_ready", in_ready, 0);
  endtask

  task automatic wait_done(output int d);
    d = -1;
    for (int n = 0; n < 100; n++) begin
      if (tile_done) begin
        d = cyc;
        break;
      end
      @(negedge clk);
    end
    if (d < 0) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: tile_done not seen within 100 cycles");
    end
  endtask

  task automatic run_tile(input int gap, output int t0, output int tl, output int d);
    int t;
    start_tile();
    for (int k = 0; k < N; k++) begin
      send(make_a(k), make_b(k), k == N-1, t);
      if (k == 0) t0 = t;
      if (k == N-1) tl = t;
      if (k == 1) repeat (gap) @(negedge clk);
    end
    wait_done(d);
  endtask

  task automatic check_c_gold(input string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("%s_c%0d%0d", tag, i, j), acc[i][j], gold(i, j));
  endtask

  task automatic check_tbl(input int s, input int base);
    for (int n = 0; n < tbl.size(); n++) begin
      if (tbl[n].scen == s) begin
        logic [N*W-1:0] row;
        row = tbl[n].is_b ? hb[base + tbl[n].rel] : ha[base + tbl[n].rel];
        chk($sformatf("s%0d_%s%0d_rel%0d", s, tbl[n].is_b ? "B" : "A", tbl[n].lane, tbl[n].rel),
            row[tbl[n].lane*W +: W], tbl[n].exp);
      end
    end
  endtask

  initial begin
    int t0, tl, d, t, base_done, base_clc;

    // Scenario 1: back-to-back slices.
    add(1,0,0,0,0);  add(1,0,0,1,1);  add(1,0,0,2,2);  add(1,0,0,4,4);  add(1,0,0,5,0);
    add(1,0,2,2,0);  add(1,0,2,3,9);  add(1,0,2,4,10); add(1,0,2,5,11); add(1,0,2,6,12); add(1,0,2,7,0);
    add(1,0,3,4,13); add(1,0,3,7,16);
    add(1,1,1,2,2);  add(1,1,1,3,6);  add(1,1,1,5,14);
    add(1,1,3,4,4);  add(1,1,3,7,16); add(1,1,3,8,0);
    // Scenario 2: two-cycle gap after k=1.
    add(2,0,0,1,1);  add(2,0,0,2,2);  add(2,0,0,3,0);  add(2,0,0,4,0);  add(2,0,0,5,3);  add(2,0,0,6,4);
    add(2,0,3,4,13); add(2,0,3,5,14); add(2,0,3,6,0);  add(2,0,3,7,0);  add(2,0,3,8,15); add(2,0,3,9,16);
    add(2,1,2,3,3);  add(2,1,2,4,7);  add(2,1,2,5,0);  add(2,1,2,6,0);  add(2,1,2,7,11); add(2,1,2,8,15);
    // Scenario 3: K=1 sign-extreme values.
    add(3,0,0,1,128); add(3,0,3,4,128); add(3,0,3,5,0); add(3,1,0,1,127); add(3,1,3,4,127);

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_clc", clc, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tile_done", tile_done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Scenario 1
    run_tile(0, t0, tl, d);
    chk("s1_done_after_last", d - tl, 14);
    chk("s1_done_after_first", d - t0, 17);
    repeat (2) @(negedge clk);
    chk("s1_busy_idle", busy, 0);
    check_c_gold("s1");
    check_tbl(1, t0);

    // Scenario 2
    run_tile(2, t0, tl, d);
    chk("s2_done_after_first", d - t0, 19);
    chk("s2_done_after_last", d - tl, 14);
    repeat (2) @(negedge clk);
    check_c_gold("s2");
    check_tbl(2, t0);
`ifdef OS_FEEDER_PERF_CNT_EN
    chk("s2_slice_cnt", slice_cnt, 4);
    chk("s2_bubble_cnt", bubble_cnt, 2);
`endif

    // Scenario 3: slice presented with start in IDLE must be ignored.
    in_a = {N{8'h55}}; in_b = {N{8'h55}}; in_valid = 1'b1;
    start_tile();
    send({N{8'h80}}, {N{8'h7F}}, 1'b1, t0);
    wait_done(d);
    chk("s3_done_after_last", d - t0, 14);
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("s3_c%0d%0d", i, j), acc[i][j], -16256);
    check_tbl(3, t0);

    // Scenario 4: start pulses while busy are ignored.
    base_done = done_cnt; base_clc = clc_cnt;
    start_tile();
    send(make_a(0), make_b(0), 1'b0, t);
    send(make_a(1), make_b(1), 1'b0, t);
    start = 1'b1; @(negedge clk); start = 1'b0;
    send(make_a(2), make_b(2), 1'b0, t);
    send(make_a(3), make_b(3), 1'b1, tl);
    repeat (6) @(negedge clk);
    chk("s4_busy_in_drain", busy, 1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done(d);
    chk("s4_done_after_last", d - tl, 14);
    repeat (20) @(negedge clk);
    chk("s4_clc_pulses", clc_cnt - base_clc, 1);
    chk("s4_done_pulses", done_cnt - base_done, 1);
    chk("s4_busy_end", busy, 0);
    check_c_gold("s4");

    // Scenario 5: reset mid-STREAM, then a clean tile.
    start_tile();
    send(make_a(0), make_b(0), 1'b0, t);
    send(make_a(1), make_b(1), 1'b0, t);
    base_done = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("s5_rst_A", A, 0);
    chk("s5_rst_B", B, 0);
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("s5_no_done", done_cnt - base_done, 0);
    chk("s5_busy_idle", busy, 0);
    run_tile(0, t0, tl, d);
    chk("s5_done_after_last", d - tl, 14);
    repeat (2) @(negedge clk);
    check_c_gold("s5");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
